mem_access_stage: RTL and testbench

- MEM-stage controller between the EX/MEM register and the MEM/WB register; consumes the *_s4 control/data bundle and produces the load/SC result plus a pipeline stall.
- Drives a single-port data memory over a req/ack handshake.
- Performs byte-lane steering for stores and loads.
- Owns the load-link/store-conditional link register.

---
 rtl/mem_access_stage_if.sv | 16 +
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and a single-port memory (slave).
interface mem_access_stage_if #(
    parameter int unsigned BITS = 32
) ();
    logic            req;
    logic            we;
    logic            lock;
    logic [3:0]      be;
    logic [BITS-1:0] addr;
    logic [BITS-1:0] wdata;
    logic            ack;
    logic [BITS-1:0] rdata;

    modport master (output req, we, lock, be, addr, wdata, input ack, rdata);
    modport slave  (input req, we, lock, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: byte-lane steering, LL/SC link register and the data-memory handshake.
// Optional bus timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned BITS           = 32,
    parameter int unsigned ADDR_LEFT      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  sel_mem_s4,
    input  logic                  mem_rw_s4,
    input  logic                  load_link_s4,
    input  logic                  check_link_s4,
    input  logic                  atomic_s4,
    input  logic                  halt_s4,
    input  logic [3:0]            byte_en_s4,
    input  logic [BITS-1:0]       alu_out_s4,
    input  logic [BITS-1:0]       r2_data_s4,
    mem_access_stage_if.master    dmem,
    output logic [BITS-1:0]       mem_data_s4,
    output logic                  mem_err_s4,
    output logic                  stall_mem
);

    localparam int unsigned WA = BITS - 2;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic            link_valid_q;
    logic [WA-1:0]   link_addr_q;
    logic            is_ll_q;
    logic            is_sc_q;
`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
`endif

    logic            sc_c;
    logic            ll_c;
    logic            link_hit_c;
    logic [3:0]      be_c;
    logic [BITS-1:0] wdata_c;
    logic [BITS-1:0] rdata_c;
    logic            unused_c;

    assign sc_c       = check_link_s4 && !mem_rw_s4;
    assign ll_c       = load_link_s4 && mem_rw_s4;
    assign link_hit_c = link_valid_q && (link_addr_q == alu_out_s4[BITS-1:2]);
    assign stall_mem  = sel_mem_s4 && !halt_s4 && (state_q != DONE);
    assign unused_c   = ^{alu_out_s4[1:0], 32'(ADDR_LEFT), 32'(TIMEOUT_CYCLES)};

    // Store steering: replicate the byte/half across lanes; unknown lane patterns become a word write.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = r2_data_s4;
        case (byte_en_s4)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                be_c    = byte_en_s4;
                wdata_c = BITS'({4{r2_data_s4[7:0]}});
            end
            4'b0011, 4'b1100: begin
                be_c    = byte_en_s4;
                wdata_c = BITS'({2{r2_data_s4[15:0]}});
            end
            default: ;
        endcase
    end

    // Load extraction keyed on the registered (normalised) lane enables.
    always_comb begin
        rdata_c = dmem.rdata;
        case (dmem.be)
            4'b0001: rdata_c = BITS'(dmem.rdata[7:0]);
            4'b0010: rdata_c = BITS'(dmem.rdata[15:8]);
            4'b0100: rdata_c = BITS'(dmem.rdata[23:16]);
            4'b1000: rdata_c = BITS'(dmem.rdata[31:24]);
            4'b0011: rdata_c = BITS'(dmem.rdata[15:0]);
            4'b1100: rdata_c = BITS'(dmem.rdata[31:16]);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= IDLE;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            is_ll_q      <= 1'b0;
            is_sc_q      <= 1'b0;
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.lock    <= 1'b0;
            dmem.be      <= '0;
            dmem.addr    <= '0;
            dmem.wdata   <= '0;
            mem_data_s4  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
            mem_err_s4   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_mem_s4 && !halt_s4) begin
                        if (sc_c && !link_hit_c) begin
                            // Failed SC never touches memory.
                            mem_data_s4  <= '0;
                            link_valid_q <= 1'b0;
                            state_q      <= DONE;
                        end else begin
                            dmem.req   <= 1'b1;
                            dmem.we    <= !mem_rw_s4;
                            dmem.lock  <= atomic_s4;
                            dmem.be    <= be_c;
                            dmem.addr  <= {alu_out_s4[BITS-1:2], 2'b00};
                            dmem.wdata <= wdata_c;
                            is_ll_q    <= ll_c;
                            is_sc_q    <= sc_c;
`ifdef MEM_TIMEOUT_EN
                            cnt_q      <= '0;
`endif
                            state_q    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dmem.ack) begin
                        dmem.req  <= 1'b0;
                        dmem.lock <= 1'b0;
                        state_q   <= DONE;
                        if (!dmem.we) begin
                            mem_data_s4 <= rdata_c;
                        end else if (is_sc_q) begin
                            mem_data_s4 <= BITS'(1);
                        end
                        if (is_ll_q) begin
                            link_valid_q <= 1'b1;
                            link_addr_q  <= dmem.addr[BITS-1:2];
                        end else if (is_sc_q || (dmem.we && (dmem.addr[BITS-1:2] == link_addr_q))) begin
                            link_valid_q <= 1'b0;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dmem.req     <= 1'b0;
                        dmem.lock    <= 1'b0;
                        mem_data_s4  <= '0;
                        mem_err_s4   <= 1'b1;
                        link_valid_q <= 1'b0;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
`ifdef MEM_TIMEOUT_EN
                    mem_err_s4 <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef MEM_TIMEOUT_EN
    assign mem_err_s4 = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a transaction-level model of results, latency and the link register.
module tb_mem_access_stage;

    localparam int unsigned BITS = 32;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO    = 4;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned TO    = 255;
    localparam bit          TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_;
    logic        sel_mem_s4, mem_rw_s4, load_link_s4, check_link_s4, atomic_s4, halt_s4;
    logic [3:0]  byte_en_s4;
    logic [31:0] alu_out_s4, r2_data_s4;
    logic [31:0] mem_data_s4;
    logic        mem_err_s4, stall_mem;

    mem_access_stage_if #(.BITS(BITS)) dmem ();

    mem_access_stage #(.BITS(BITS), .ADDR_LEFT(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .sel_mem_s4    (sel_mem_s4),
        .mem_rw_s4     (mem_rw_s4),
        .load_link_s4  (load_link_s4),
        .check_link_s4 (check_link_s4),
        .atomic_s4     (atomic_s4),
        .halt_s4       (halt_s4),
        .byte_en_s4    (byte_en_s4),
        .alu_out_s4    (alu_out_s4),
        .r2_data_s4    (r2_data_s4),
        .dmem          (dmem),
        .mem_data_s4   (mem_data_s4),
        .mem_err_s4    (mem_err_s4),
        .stall_mem     (stall_mem)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Architectural model state.
    bit          m_link_v;
    logic [29:0] m_link_a;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lanes(input logic [3:0] be);
        int n = 0;
        for (int i = 0; i < 4; i++) if (be[i]) n++;
        return n;
    endfunction

    function automatic logic [3:0] norm_be(input logic [3:0] be);
        if (be == 4'b0011 || be == 4'b1100 || be == 4'b1111 || lanes(be) == 1) return be;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] steer(input logic [3:0] be, input logic [31:0] r2);
        int n = lanes(be);
        if (n == 1) return {4{r2[7:0]}};
        if (n == 2) return {2{r2[15:0]}};
        return r2;
    endfunction

    function automatic logic [31:0] extract(input logic [3:0] be, input logic [31:0] w);
        int lo = 0;
        int n  = 0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (n == 0) lo = i;
                n++;
            end
        end
        if (n == 4) return w;
        return (w >> (8 * lo)) & ((32'h1 << (8 * n)) - 32'h1);
    endfunction

    // One instruction through S4; delay = BUSY cycles before ack (negative = never ack).
    task automatic run_op(input string tag, input bit rw, input bit ll, input bit sc, input bit atomic,
                          input logic [3:0] be, input logic [31:0] addr, input logic [31:0] r2,
                          input logic [31:0] rdata, input int delay, input bit has_lit, input logic [31:0] lit);
        bit          is_sc  = sc && !rw;
        bit          is_ll  = ll && rw;
        bit          hit    = m_link_v && (m_link_a == addr[31:2]);
        bit          access = !(is_sc && !hit);
        logic [3:0]  ebe    = norm_be(be);
        logic [31:0] ewd    = steer(ebe, r2);
        bit          tmo    = access && TO_EN && (delay < 0 || delay >= int'(TO));
        int          busy   = !access ? 0 : (tmo ? int'(TO) : delay + 1);
        int          lat    = busy + 2;
        logic [31:0] edata;

        if (!access || tmo) begin
            edata    = 32'h0;
            m_link_v = 1'b0;
        end else if (rw) begin
            edata = extract(ebe, rdata);
            if (is_ll) begin
                m_link_v = 1'b1;
                m_link_a = addr[31:2];
            end
        end else begin
            edata = is_sc ? 32'h1 : m_data;
            if (is_sc || addr[31:2] == m_link_a) m_link_v = 1'b0;
        end
        m_data = edata;

        sel_mem_s4 = 1'b1; halt_s4 = 1'b0; mem_rw_s4 = rw; load_link_s4 = ll;
        check_link_s4 = sc; atomic_s4 = atomic; byte_en_s4 = be; alu_out_s4 = addr; r2_data_s4 = r2;
        for (int cyc = 0; cyc < lat; cyc++) begin
            dmem.ack   = access && !tmo && (cyc == delay + 1);
            dmem.rdata = dmem.ack ? rdata : 32'h0;
            @(negedge clk);
            chk({tag, " stall"}, 32'(stall_mem), 32'(cyc < lat - 1));
            if (cyc >= 1 && cyc <= busy) begin
                chk({tag, " req"},   32'(dmem.req),  32'h1);
                chk({tag, " addr"},  dmem.addr,      {addr[31:2], 2'b00});
                chk({tag, " we"},    32'(dmem.we),   32'(!rw));
                chk({tag, " be"},    32'(dmem.be),   32'(ebe));
                chk({tag, " lock"},  32'(dmem.lock), 32'(atomic));
                if (!rw) chk({tag, " wdata"}, dmem.wdata, ewd);
            end else begin
                chk({tag, " req idle"}, 32'(dmem.req), 32'h0);
            end
            if (cyc == lat - 1) begin
                chk({tag, " data"},   mem_data_s4,       edata);
                chk({tag, " err"},    32'(mem_err_s4),   32'(tmo));
                chk({tag, " unlock"}, 32'(dmem.lock),    32'h0);
                if (has_lit) chk({tag, " literal"}, mem_data_s4, lit);
            end
            @(posedge clk);
            #1;
        end
        dmem.ack = 1'b0;
    endtask

    task automatic idle_op(input string tag, input bit sel, input bit halt, input int n);
        sel_mem_s4 = sel; halt_s4 = halt; mem_rw_s4 = 1'b1; load_link_s4 = 1'b0; check_link_s4 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, " stall"}, 32'(stall_mem),  32'h0);
            chk({tag, " req"},   32'(dmem.req),   32'h0);
            chk({tag, " data"},  mem_data_s4,     m_data);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ = 1'b0;
        sel_mem_s4 = 1'b0; mem_rw_s4 = 1'b0; load_link_s4 = 1'b0; check_link_s4 = 1'b0;
        atomic_s4 = 1'b0; halt_s4 = 1'b0; byte_en_s4 = 4'h0; alu_out_s4 = '0; r2_data_s4 = '0;
        dmem.ack = 1'b0; dmem.rdata = '0;
        m_link_v = 1'b0; m_link_a = '0; m_data = '0;
        #1;
        chk("reset req",   32'(dmem.req),   32'h0);
        chk("reset we",    32'(dmem.we),    32'h0);
        chk("reset lock",  32'(dmem.lock),  32'h0);
        chk("reset be",    32'(dmem.be),    32'h0);
        chk("reset addr",  dmem.addr,       32'h0);
        chk("reset wdata", dmem.wdata,      32'h0);
        chk("reset data",  mem_data_s4,     32'h0);
        chk("reset err",   32'(mem_err_s4), 32'h0);
        chk("reset stall", 32'(stall_mem),  32'h0);
        @(posedge clk); #1;
        rst_ = 1'b1;
        @(posedge clk); #1;

        //     tag            rw ll sc at be       addr          r2            rdata         dly lit
        run_op("word load",   1, 0, 0, 0, 4'b1111, 32'h0000_0104, 32'h0,        32'hDEADBEEF, 1, 1, 32'hDEADBEEF);
        run_op("byte store",  0, 0, 0, 0, 4'b1000, 32'h0000_0203, 32'h0000_00A5, 32'h0,       0, 1, 32'hDEADBEEF);
        run_op("half load hi",1, 0, 0, 0, 4'b1100, 32'h0000_0108, 32'h0,        32'h8123_4567, 0, 1, 32'h0000_8123);
        run_op("byte load 1", 1, 0, 0, 0, 4'b0010, 32'h0000_0111, 32'h0,        32'h1122_3344, 2, 1, 32'h0000_0033);
        run_op("half load lo",1, 0, 0, 0, 4'b0011, 32'h0000_0120, 32'h0,        32'hCAFE_F00D, 0, 1, 32'h0000_F00D);
        run_op("odd be store",0, 0, 0, 0, 4'b0110, 32'h0000_0130, 32'h1234_5678, 32'h0,       1, 0, 32'h0);
        run_op("half store",  0, 0, 0, 0, 4'b0011, 32'h0000_0142, 32'hAAAA_BEEF, 32'h0,       0, 0, 32'h0);
        run_op("byte ld 3",   1, 0, 0, 0, 4'b0100, 32'h0000_0150, 32'h0,        32'hA1B2_C3D4, 3, 1, 32'h0000_00B2);
        idle_op("halt", 1, 1, 2);
        idle_op("no sel", 0, 0, 1);

        run_op("ll",          1, 1, 0, 1, 4'b1111, 32'h0000_0300, 32'h0,        32'h0000_0055, 0, 1, 32'h0000_0055);
        run_op("sc hit",      0, 0, 1, 1, 4'b1111, 32'h0000_0300, 32'h0000_0007, 32'h0,       0, 1, 32'h0000_0001);
        run_op("sc again",    0, 0, 1, 0, 4'b1111, 32'h0000_0300, 32'h0000_0007, 32'h0,       0, 1, 32'h0000_0000);

        run_op("ll 2",        1, 1, 0, 0, 4'b1111, 32'h0000_0300, 32'h0,        32'h0000_0066, 0, 0, 32'h0);
        run_op("break store", 0, 0, 0, 0, 4'b0100, 32'h0000_0302, 32'h0000_0099, 32'h0,       0, 0, 32'h0);
        run_op("sc broken",   0, 0, 1, 0, 4'b1111, 32'h0000_0300, 32'h0000_0001, 32'h0,       0, 1, 32'h0000_0000);

        run_op("ll 3",        1, 1, 0, 0, 4'b1111, 32'h0000_0300, 32'h0,        32'h0000_0077, 1, 0, 32'h0);
        run_op("other store", 0, 0, 0, 0, 4'b1111, 32'h0000_0304, 32'h0000_1111, 32'h0,       0, 0, 32'h0);
        run_op("sc kept",     0, 0, 1, 0, 4'b1111, 32'h0000_0300, 32'h0000_0002, 32'h0,       1, 1, 32'h0000_0001);

        run_op("ll 4",        1, 1, 0, 0, 4'b1111, 32'h0000_0300, 32'h0,        32'h0000_0088, 0, 0, 32'h0);
        run_op("sc wrong adr",0, 0, 1, 0, 4'b1111, 32'h0000_0304, 32'h0000_0003, 32'h0,       0, 1, 32'h0000_0000);
        run_op("sc after miss",0,0, 1, 0, 4'b1111, 32'h0000_0300, 32'h0000_0003, 32'h0,       0, 1, 32'h0000_0000);

`ifdef MEM_TIMEOUT_EN
        run_op("ll 5",        1, 1, 0, 0, 4'b1111, 32'h0000_0300, 32'h0,        32'h0000_0099, 0, 0, 32'h0);
        run_op("timeout",     1, 0, 0, 1, 4'b1111, 32'h0000_0500, 32'h0,        32'h0,        -1, 1, 32'h0000_0000);
        run_op("sc after to", 0, 0, 1, 0, 4'b1111, 32'h0000_0300, 32'h0000_0004, 32'h0,       0, 1, 32'h0000_0000);
        run_op("ack at expiry",1,0, 0, 0, 4'b1111, 32'h0000_0504, 32'h0,        32'h0BAD_CAFE, 3, 1, 32'h0BAD_CAFE);
`endif

        // Asynchronous reset in the middle of a BUSY access, with a live link.
        run_op("ll pre-reset",1, 1, 0, 0, 4'b1111, 32'h0000_0300, 32'h0,        32'h0000_00AA, 0, 0, 32'h0);
        sel_mem_s4 = 1'b1; halt_s4 = 1'b0; mem_rw_s4 = 1'b1; load_link_s4 = 1'b0; check_link_s4 = 1'b0;
        atomic_s4 = 1'b1; byte_en_s4 = 4'b1111; alu_out_s4 = 32'h0000_0400;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy before reset req", 32'(dmem.req), 32'h1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("mid reset req",   32'(dmem.req),  32'h0);
        chk("mid reset lock",  32'(dmem.lock), 32'h0);
        chk("mid reset addr",  dmem.addr,      32'h0);
        chk("mid reset data",  mem_data_s4,    32'h0);
        chk("mid reset stall", 32'(stall_mem), 32'h1);
        sel_mem_s4 = 1'b0;
        m_link_v = 1'b0;
        m_data   = 32'h0;
        @(posedge clk); #1;
        rst_ = 1'b1;
        idle_op("post reset", 0, 0, 1);
        run_op("sc post reset",0, 0, 1, 0, 4'b1111, 32'h0000_0300, 32'h0000_0005, 32'h0,       0, 1, 32'h0000_0000);
        idle_op("end", 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
